// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the multi-port register bank.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // Widest scoreboard popcount supports (ADDR_W up to 8).
    localparam int POP_MAX_W = 256;

    typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
    typedef logic [DATA_W_DEF-1:0] reg_word_t;

    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < POP_MAX_W; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_wsel.sv
// Write-select priority encoder: finds the highest enabled write port
// targeting addr. Writes to register 0 never hit when ZERO_REG is set.
module regfile_wsel
    import regfile_pkg::*;
#(
    parameter int NUM_WR   = 2,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int SEL_W    = 1
) (
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [ADDR_W-1:0]        addr,
    output logic                     hit,
    output logic [SEL_W-1:0]         sel
);

    // Ascending scan: a later (higher) matching port overrides earlier ones.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int unsigned w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == addr)) begin
                hit = 1'b1;
                sel = SEL_W'(w);
            end
        end
        if ((ZERO_REG != 0) && (addr == '0)) begin
            hit = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register bank with write-to-read bypass, synchronous clear
// and a per-register busy scoreboard with a registered busy count.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic [NUM_WR-1:0]        wr_clr,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int SEL_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

    logic [DATA_W-1:0]    mem [DEPTH];
    logic [DEPTH-1:0]     busy;
    logic [DEPTH-1:0]     busy_nxt;
    logic [DEPTH-1:0]     set_vec;
    logic [DEPTH-1:0]     clr_vec;
    logic [POP_MAX_W-1:0] busy_ext;
    logic [DEPTH-1:0]     wr_hit;
    logic [SEL_W-1:0]     wr_sel [DEPTH];

    // One write-select encoder per entry resolves multi-port conflicts.
    for (genvar r = 0; r < DEPTH; r++) begin : g_wsel
        regfile_wsel #(
            .NUM_WR  (NUM_WR),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG),
            .SEL_W   (SEL_W)
        ) u_wsel (
            .wr_en  (wr_en),
            .wr_addr(wr_addr),
            .addr   (ADDR_W'(r)),
            .hit    (wr_hit[r]),
            .sel    (wr_sel[r])
        );
    end

    // Next scoreboard state: issue (set) wins over a retiring write (clear).
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (iss_en) begin
            set_vec[iss_addr] = 1'b1;
        end
        for (int unsigned w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && wr_clr[w]) begin
                clr_vec[wr_addr[w*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
        busy_nxt = set_vec | (busy & ~clr_vec);
        if (ZERO_REG != 0) begin
            busy_nxt[0] = 1'b0;
        end
    end

    // Zero-extend so the shared popcount helper can be used at any depth.
    always_comb begin
        busy_ext = '0;
        busy_ext[DEPTH-1:0] = busy_nxt;
    end

    // Storage, scoreboard and busy count update; reset drops all writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                mem[r] <= '0;
            end
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                if (wr_hit[r]) begin
                    mem[r] <= wr_data[int'(wr_sel[r])*DATA_W +: DATA_W];
                end
            end
            busy     <= busy_nxt;
            busy_cnt <= (ADDR_W+1)'(popcount(busy_ext));
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              byp_hit;
        logic [SEL_W-1:0]  byp_sel;
        logic              clr_match;
        logic              iss_match;
        logic [DATA_W-1:0] word;
        logic              bsy;

        assign a         = rd_addr[p*ADDR_W +: ADDR_W];
        assign iss_match = iss_en && (iss_addr == a);

        regfile_wsel #(
            .NUM_WR  (NUM_WR),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG),
            .SEL_W   (SEL_W)
        ) u_byp (
            .wr_en  (wr_en),
            .wr_addr(wr_addr),
            .addr   (a),
            .hit    (byp_hit),
            .sel    (byp_sel)
        );

        // Detect a same-cycle clearing write to this read address.
        always_comb begin
            clr_match = 1'b0;
            for (int unsigned w = 0; w < NUM_WR; w++) begin
                if (wr_en[w] && wr_clr[w] && (wr_addr[w*ADDR_W +: ADDR_W] == a)) begin
                    clr_match = 1'b1;
                end
            end
        end

        // Read mux: reset, then zero register, then bypass, then storage.
        always_comb begin
            word = mem[a];
            bsy  = busy[a];
            if ((BYPASS != 0) && byp_hit) begin
                word = wr_data[int'(byp_sel)*DATA_W +: DATA_W];
            end
            if ((ZERO_REG != 0) && (a == '0)) begin
                word = '0;
            end
            // A bypassed retiring value needs no stall unless re-issued now.
            if ((BYPASS != 0) && clr_match && !iss_match) begin
                bsy = 1'b0;
            end
            if (rst) begin
                word = '0;
                bsy  = 1'b0;
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = word;
        assign rd_busy[p]                  = bsy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a bypassing and a non-bypassing
// instance share stimulus and are compared each cycle against an array model.
module tb_regfile_mp;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data, rd_data_nb;
    logic [1:0]  rd_busy, rd_busy_nb;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic [1:0]  wr_clr;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic [5:0]  busy_cnt, busy_cnt_nb;

    int checks = 0;
    int errors = 0;

    reg_word_t m_mem [32];
    bit        m_busy [32];
    bit        started = 1'b0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)) u_dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_clr(wr_clr),
        .iss_en(iss_en), .iss_addr(iss_addr), .busy_cnt(busy_cnt)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_clr(wr_clr),
        .iss_en(iss_en), .iss_addr(iss_addr), .busy_cnt(busy_cnt_nb)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    task automatic idle();
        wr_en    = '0;
        wr_clr   = '0;
        iss_en   = 1'b0;
    endtask

    task automatic wr(input int w, input logic [4:0] a, input logic [31:0] d, input logic c);
        wr_en[w]           = 1'b1;
        wr_addr[w*5 +: 5]  = a;
        wr_data[w*32 +: 32] = d;
        wr_clr[w]          = c;
    endtask

    task automatic iss(input logic [4:0] a);
        iss_en   = 1'b1;
        iss_addr = a;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Reference model: whole-register semantics applied at every rising edge.
    always @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                m_mem[r]  = '0;
                m_busy[r] = 1'b0;
            end
            started = 1'b1;
        end else begin
            bit nb [32];
            for (int r = 0; r < 32; r++) nb[r] = m_busy[r];
            for (int w = 0; w < 2; w++)
                if (wr_en[w] && wr_clr[w]) nb[wr_addr[w*5 +: 5]] = 1'b0;
            if (iss_en) nb[iss_addr] = 1'b1;
            nb[0] = 1'b0;
            for (int w = 0; w < 2; w++)
                if (wr_en[w] && wr_addr[w*5 +: 5] != 5'd0)
                    m_mem[wr_addr[w*5 +: 5]] = wr_data[w*32 +: 32];
            for (int r = 0; r < 32; r++) m_busy[r] = nb[r];
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (started) begin
            int cnt;
            for (int p = 0; p < 2; p++) begin
                logic [4:0]  a;
                logic [31:0] e_nb, e_b;
                logic        z_nb, z_b, clrm;
                a    = rd_addr[p*5 +: 5];
                e_nb = (a == 5'd0) ? 32'd0 : m_mem[a];
                e_b  = e_nb;
                clrm = 1'b0;
                for (int w = 0; w < 2; w++) begin
                    if (wr_en[w] && wr_addr[w*5 +: 5] == a && a != 5'd0)
                        e_b = wr_data[w*32 +: 32];
                    if (wr_en[w] && wr_clr[w] && wr_addr[w*5 +: 5] == a)
                        clrm = 1'b1;
                end
                z_nb = m_busy[a];
                z_b  = (clrm && !(iss_en && iss_addr == a)) ? 1'b0 : m_busy[a];
                if (rst) begin
                    e_nb = '0; e_b = '0; z_nb = 1'b0; z_b = 1'b0;
                end
                chk($sformatf("rd_data_byp[%0d]", p), rd_data[p*32 +: 32], e_b);
                chk($sformatf("rd_data_nb[%0d]", p), rd_data_nb[p*32 +: 32], e_nb);
                chk($sformatf("rd_busy_byp[%0d]", p), rd_busy[p], z_b);
                chk($sformatf("rd_busy_nb[%0d]", p), rd_busy_nb[p], z_nb);
            end
            cnt = 0;
            for (int r = 0; r < 32; r++) cnt += int'(m_busy[r]);
            chk("busy_cnt_byp", busy_cnt, cnt);
            chk("busy_cnt_nb", busy_cnt_nb, cnt);
        end
    end

    initial begin
        rst = 1'b1; rd_addr = '0; wr_addr = '0; wr_data = '0; iss_addr = '0;
        idle();
        nxt();
        rst = 1'b0;

        // Reset contents: every register reads 0 and is not busy.
        for (int i = 0; i < 16; i++) begin
            rd_addr[4:0] = 5'(i);
            rd_addr[9:5] = 5'(i + 16);
            mid();
            chk("reset_rd_lo", rd_data[31:0], 32'd0);
            chk("reset_rd_hi", rd_data[63:32], 32'd0);
            chk("reset_busy", rd_busy, 2'b00);
            chk("reset_cnt", busy_cnt, 6'd0);
            nxt();
        end

        // Dual write to r5: port 1 wins on bypass and in storage.
        wr(0, 5'd5, 32'hAAAA0000, 1'b0);
        wr(1, 5'd5, 32'h5555FFFF, 1'b0);
        rd_addr = {5'd5, 5'd5};
        mid();
        chk("conflict_bypass", rd_data[31:0], 32'h5555FFFF);
        chk("conflict_nb_old", rd_data_nb[31:0], 32'h0);
        nxt(); idle();
        mid();
        chk("conflict_stored", rd_data[31:0], 32'h5555FFFF);
        chk("conflict_stored_nb", rd_data_nb[63:32], 32'h5555FFFF);
        nxt();

        // Register 0 ignores writes and issues.
        wr(0, 5'd0, 32'hDEADBEEF, 1'b0);
        iss(5'd0);
        rd_addr = {5'd5, 5'd0};
        mid();
        chk("zero_rd", rd_data[31:0], 32'd0);
        chk("zero_busy", rd_busy[0], 1'b0);
        nxt(); idle();
        mid();
        chk("zero_rd_after", rd_data_nb[31:0], 32'd0);
        chk("zero_cnt", busy_cnt, 6'd0);
        nxt();

        // Issue r7, then issue and retire r7 in the same cycle.
        iss(5'd7);
        rd_addr = {5'd5, 5'd7};
        nxt(); idle();
        mid();
        chk("race_pre_cnt", busy_cnt, 6'd1);
        nxt();
        iss(5'd7);
        wr(0, 5'd7, 32'h12, 1'b1);
        mid();
        chk("race_busy_byp", rd_busy[0], 1'b1);
        chk("race_data_byp", rd_data[31:0], 32'h12);
        nxt(); idle();
        mid();
        chk("race_busy_after", rd_busy_nb[0], 1'b1);
        chk("race_mem", rd_data_nb[31:0], 32'h12);
        chk("race_cnt", busy_cnt, 6'd1);
        nxt();

        // Clearing write without re-issue: bypassing instance reports not busy.
        wr(1, 5'd7, 32'h34, 1'b1);
        mid();
        chk("clr_busy_byp", rd_busy[0], 1'b0);
        chk("clr_busy_nb", rd_busy_nb[0], 1'b1);
        chk("clr_data_byp", rd_data[31:0], 32'h34);
        nxt(); idle();
        mid();
        chk("clr_cnt", busy_cnt, 6'd0);
        nxt();

        // Non-bypassing read of r3 sees the old value until the edge.
        wr(1, 5'd3, 32'h1, 1'b0);
        rd_addr = {5'd5, 5'd3};
        mid();
        chk("nb_old", rd_data_nb[31:0], 32'h0);
        chk("byp_new", rd_data[31:0], 32'h1);
        nxt(); idle();
        mid();
        chk("nb_new", rd_data_nb[31:0], 32'h1);
        nxt();

        // Reset mid-operation drops concurrent writes and issues.
        for (int r = 1; r <= 4; r++) begin
            iss(5'(r));
            nxt();
        end
        idle();
        mid();
        chk("pre_rst_cnt", busy_cnt, 6'd4);
        nxt();
        rst = 1'b1;
        wr(0, 5'd9, 32'hCAFE0009, 1'b0);
        wr(1, 5'd10, 32'hCAFE000A, 1'b1);
        iss(5'd11);
        rd_addr = {5'd10, 5'd9};
        mid();
        chk("rst_rd0", rd_data[31:0], 32'd0);
        chk("rst_rd1", rd_data[63:32], 32'd0);
        chk("rst_busy", rd_busy, 2'b00);
        nxt();
        rst = 1'b0; idle();
        mid();
        chk("post_rst_cnt", busy_cnt, 6'd0);
        chk("post_rst_r9", rd_data_nb[31:0], 32'd0);
        nxt();
        rd_addr = {5'd3, 5'd5};
        mid();
        chk("post_rst_r5", rd_data[31:0], 32'd0);
        chk("post_rst_r3", rd_data_nb[63:32], 32'd0);
        nxt();

        // Randomized traffic, narrow address range to provoke collisions.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 127) == 0);
            for (int p = 0; p < 2; p++)
                rd_addr[p*5 +: 5] = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            for (int w = 0; w < 2; w++) begin
                wr_addr[w*5 +: 5]   = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
                wr_data[w*32 +: 32] = $urandom;
            end
            wr_en    = 2'($urandom);
            wr_clr   = 2'($urandom);
            iss_en   = ($urandom_range(0, 2) != 0);
            iss_addr = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            nxt();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
